// File: rtl/mskand_hpc2_tof_pipe_if.sv
// Handshake and data bundle for the masked Toffoli pipeline.
//   in_valid/in_ready : operand triple ina/inb/inc (W bits x d shares each)
//   rnd_valid/rnd_ready : fresh randomness, W*d*(d-1)/2 bits
//   out_valid/out_ready : output sharing of (ina & inb) ^ inc
// Share i of bit w lives at index w*d+i on every sharing bus.
// master = stimulus/consumer side, slave = the pipeline.
interface mskand_hpc2_tof_pipe_if #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 8
);
  localparam int unsigned RND_W = W * ((d * (d - 1)) / 2);

  logic               in_valid;
  logic               in_ready;
  logic [W*d-1:0]     ina;
  logic [W*d-1:0]     inb;
  logic [W*d-1:0]     inc;
  logic               rnd_valid;
  logic               rnd_ready;
  logic [RND_W-1:0]   rnd;
  logic               out_valid;
  logic               out_ready;
  logic [W*d-1:0]     out;

  modport master (
    output in_valid, ina, inb, inc, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, out
  );

  modport slave (
    input  in_valid, ina, inb, inc, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, out
  );
endinterface

// File: rtl/mskand_hpc2_tof_pipe.sv
// Two-stage elastic pipeline computing a d-share masked (a & b) ^ c per bit
// with an HPC2-style AND gadget, W bits in parallel.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high; clears valids and all data registers
//   bus  : mskand_hpc2_tof_pipe_if.slave (operands, randomness, result)
// SWAP selects the early (randomised) operand: 0 -> inb, 1 -> ina.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module mskand_hpc2_tof_pipe #(
  parameter int unsigned d    = `DEFAULTSHARES,
  parameter int unsigned W    = 8,
  parameter int unsigned SWAP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  mskand_hpc2_tof_pipe_if.slave  bus
);

  localparam int unsigned HPC2RND = (d * (d - 1)) / 2;
  localparam int unsigned RND_W   = W * HPC2RND;
  localparam int unsigned SW      = W * d;

  // Index of pair (i<j) in lexicographic order among the d*(d-1)/2 pairs.
  function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  if (d < 2) begin : g_bad_d
    $error("mskand_hpc2_tof_pipe: d must be >= 2");
  end

  logic              v1_q, v1_d, v2_q, v2_d;
  logic [SW-1:0]     l1_q, l1_d, e1_q, e1_d, c1_q, c1_d, out_q, out_d;
  logic [RND_W-1:0]  s_lo_q, s_lo_d, s_hi_q, s_hi_d, rr_q, rr_d;

  logic              pipe_ready_c, t_c, a2_c;
  logic [SW-1:0]     e_c, l_c, share_c;
  logic [RND_W-1:0]  s_lo_c, s_hi_c;

  // Handshake: ready never depends on its own channel's valid.
  assign pipe_ready_c  = !v1_q || !v2_q || bus.out_ready;
  assign t_c           = bus.in_valid && bus.rnd_valid && pipe_ready_c && !rst;
  assign a2_c          = v1_q && (!v2_q || bus.out_ready);
  assign bus.in_ready  = pipe_ready_c && bus.rnd_valid && !rst;
  assign bus.rnd_ready = pipe_ready_c && bus.in_valid && !rst;
  assign bus.out_valid = v2_q;
  assign bus.out       = out_q;

  // Early / late operand selection.
  if (SWAP != 0) begin : g_swap
    assign e_c = bus.ina;
    assign l_c = bus.inb;
  end else begin : g_noswap
    assign e_c = bus.inb;
    assign l_c = bus.ina;
  end

  // Stage-1 randomisation of the early operand: s_ij = E_j ^ r_ij (lo), s_ji = E_i ^ r_ij (hi).
  for (genvar w = 0; w < W; w++) begin : g_s1_bit
    for (genvar i = 0; i < d; i++) begin : g_i
      for (genvar j = i + 1; j < d; j++) begin : g_j
        localparam int unsigned P = w * HPC2RND + pidx(i, j);
        assign s_lo_c[P] = e_c[w*d+j] ^ bus.rnd[P];
        assign s_hi_c[P] = e_c[w*d+i] ^ bus.rnd[P];
      end
    end
  end

  // Stage-2 share computation from registered stage-1 values only.
  for (genvar w = 0; w < W; w++) begin : g_s2_bit
    for (genvar i = 0; i < d; i++) begin : g_i
      logic [d-1:0] terms;
      for (genvar j = 0; j < d; j++) begin : g_j
        if (j == i) begin : g_diag
          assign terms[j] = (l1_q[w*d+i] & e1_q[w*d+i]) ^ c1_q[w*d+i];
        end else if (j > i) begin : g_lo
          localparam int unsigned P = w * HPC2RND + pidx(i, j);
          assign terms[j] = (~l1_q[w*d+i] & rr_q[P]) ^ (l1_q[w*d+i] & s_lo_q[P]);
        end else begin : g_hi
          localparam int unsigned P = w * HPC2RND + pidx(j, i);
          assign terms[j] = (~l1_q[w*d+i] & rr_q[P]) ^ (l1_q[w*d+i] & s_hi_q[P]);
        end
      end
      assign share_c[w*d+i] = ^terms;
    end
  end

  // Valid tracking.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (t_c)               v1_d = 1'b1;
    else if (a2_c)         v1_d = 1'b0;
    if (a2_c)              v2_d = 1'b1;
    else if (bus.out_ready) v2_d = 1'b0;
  end

  // Data registers load only on their enable.
  always_comb begin
    l1_d   = l1_q;
    e1_d   = e1_q;
    c1_d   = c1_q;
    rr_d   = rr_q;
    s_lo_d = s_lo_q;
    s_hi_d = s_hi_q;
    out_d  = out_q;
    if (t_c) begin
      l1_d   = l_c;
      e1_d   = e_c;
      c1_d   = bus.inc;
      rr_d   = bus.rnd;
      s_lo_d = s_lo_c;
      s_hi_d = s_hi_c;
    end
    if (a2_c) begin
      out_d = share_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      l1_q   <= '0;
      e1_q   <= '0;
      c1_q   <= '0;
      rr_q   <= '0;
      s_lo_q <= '0;
      s_hi_q <= '0;
      out_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      l1_q   <= l1_d;
      e1_q   <= e1_d;
      c1_q   <= c1_d;
      rr_q   <= rr_d;
      s_lo_q <= s_lo_d;
      s_hi_q <= s_hi_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: tb/tb_mskand_hpc2_tof_pipe.sv
// Directed and randomised checks of mskand_hpc2_tof_pipe: d=2/W=8 with both
// SWAP settings (shared stimulus), and d=3/W=4 with a scoreboard.
module tb_mskand_hpc2_tof_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mskand_hpc2_tof_pipe_if #(.d(2), .W(8)) if0 ();
  mskand_hpc2_tof_pipe_if #(.d(2), .W(8)) if1 ();
  mskand_hpc2_tof_pipe_if #(.d(3), .W(4)) if2 ();

  mskand_hpc2_tof_pipe #(.d(2), .W(8), .SWAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mskand_hpc2_tof_pipe #(.d(2), .W(8), .SWAP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  mskand_hpc2_tof_pipe #(.d(3), .W(4), .SWAP(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // dut1 sees exactly the stimulus of dut0.
  assign if1.in_valid  = if0.in_valid;
  assign if1.ina       = if0.ina;
  assign if1.inb       = if0.inb;
  assign if1.inc       = if0.inc;
  assign if1.rnd_valid = if0.rnd_valid;
  assign if1.rnd       = if0.rnd;
  assign if1.out_ready = if0.out_ready;

  int tests = 0;
  int fails = 0;

  // Item operands for the directed d=2 tests.
  logic [7:0] it_a [3] = '{8'hA5, 8'h5A, 8'hFF};
  logic [7:0] it_b [3] = '{8'h3C, 8'hC3, 8'h0F};
  logic [7:0] it_c [3] = '{8'h0F, 8'hF0, 8'h33};
  logic [7:0] it_x [3] = '{8'h2B, 8'hB2, 8'h3C};  // hand-computed (a & b) ^ c

  function automatic logic [15:0] sh2(input logic [7:0] x, input logic [7:0] m);
    logic [15:0] s;
    for (int w = 0; w < 8; w++) begin
      s[2*w]   = m[w];
      s[2*w+1] = x[w] ^ m[w];
    end
    return s;
  endfunction

  function automatic logic [7:0] um2(input logic [15:0] s);
    logic [7:0] x;
    for (int w = 0; w < 8; w++) x[w] = s[2*w] ^ s[2*w+1];
    return x;
  endfunction

  function automatic logic [11:0] sh3(input logic [3:0] x, input logic [3:0] m1, input logic [3:0] m2);
    logic [11:0] s;
    for (int w = 0; w < 4; w++) begin
      s[3*w]   = m1[w];
      s[3*w+1] = m2[w];
      s[3*w+2] = x[w] ^ m1[w] ^ m2[w];
    end
    return s;
  endfunction

  function automatic logic [3:0] um3(input logic [11:0] s);
    logic [3:0] x;
    for (int w = 0; w < 4; w++) x[w] = s[3*w] ^ s[3*w+1] ^ s[3*w+2];
    return x;
  endfunction

  // For d=2 the gadget reduces to share_i = L_i & E ^ C_i ^ r (E unmasked).
  function automatic logic [15:0] exp_sh2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                          input logic [7:0] ma, input logic [7:0] mb, input logic [7:0] mc,
                                          input logic [7:0] r, input bit swap);
    logic [7:0] l, ml, e, s0, s1;
    logic [15:0] o;
    l  = swap ? b : a;
    ml = swap ? mb : ma;
    e  = swap ? a : b;
    s0 = (ml & e) ^ mc ^ r;
    s1 = ((l ^ ml) & e) ^ (c ^ mc) ^ r;
    for (int w = 0; w < 8; w++) begin
      o[2*w]   = s0[w];
      o[2*w+1] = s1[w];
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input int k, input logic [7:0] ma, input logic [7:0] mb,
                        input logic [7:0] mc, input logic [7:0] r);
    if0.ina = sh2(it_a[k], ma);
    if0.inb = sh2(it_b[k], mb);
    if0.inc = sh2(it_c[k], mc);
    if0.rnd = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.in_valid = 1'b1; if0.rnd_valid = 1'b1; if0.out_ready = 1'b1;
    drive0(0, 8'h12, 8'h34, 8'h56, 8'h78);
    step();
    #1;
    tests++; if (if0.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", if0.in_ready); end
    tests++; if (if0.rnd_ready !== 1'b0) begin fails++; $display("FAIL reset_rnd_ready: got %b want 0", if0.rnd_ready); end
    tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", if0.out_valid); end
    tests++; if (if0.out !== 16'h0000) begin fails++; $display("FAIL reset_out: got %h want 0000", if0.out); end
    tests++; if (if2.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid_d3: got %b want 0", if2.out_valid); end
    if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  // Nominal latency and value, with random, all-zero and all-one randomness on both SWAP settings.
  task automatic test_basic_rnd_swap();
    logic [7:0] ma, mb, mc, r;
    logic [7:0] rv [3];
    rv[0] = 8'($urandom); rv[1] = 8'h00; rv[2] = 8'hFF;
    if0.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      ma = 8'($urandom); mb = 8'($urandom); mc = 8'($urandom); r = rv[n];
      drive0(0, ma, mb, mc, r);
      if0.in_valid = 1'b1; if0.rnd_valid = 1'b1;
      #1;
      tests++; if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready[%0d]: got %b want 1", n, if0.in_ready); end
      @(posedge clk); #1;
      if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
      tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat1[%0d]: got %b want 0", n, if0.out_valid); end
      step();
      tests++; if (if0.out_valid !== 1'b1) begin fails++; $display("FAIL basic_lat2[%0d]: got %b want 1", n, if0.out_valid); end
      tests++; if (um2(if0.out) !== 8'h2B) begin fails++; $display("FAIL basic_val_swap0[%0d]: got %h want 2b", n, um2(if0.out)); end
      tests++; if (um2(if1.out) !== 8'h2B) begin fails++; $display("FAIL basic_val_swap1[%0d]: got %h want 2b", n, um2(if1.out)); end
      tests++;
      if (if0.out !== exp_sh2(it_a[0], it_b[0], it_c[0], ma, mb, mc, r, 1'b0)) begin
        fails++; $display("FAIL basic_shares_swap0[%0d]: got %h want %h", n, if0.out,
                          exp_sh2(it_a[0], it_b[0], it_c[0], ma, mb, mc, r, 1'b0));
      end
      tests++;
      if (if1.out !== exp_sh2(it_a[0], it_b[0], it_c[0], ma, mb, mc, r, 1'b1)) begin
        fails++; $display("FAIL basic_shares_swap1[%0d]: got %h want %h", n, if1.out,
                          exp_sh2(it_a[0], it_b[0], it_c[0], ma, mb, mc, r, 1'b1));
      end
      step();
      tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain[%0d]: got %b want 0", n, if0.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ma [3], mb [3], mc [3];
    logic [7:0] res [3];
    logic [15:0] snap;
    int acc, got;
    logic fire, ov;
    logic [7:0] val;
    for (int k = 0; k < 3; k++) begin ma[k] = 8'($urandom); mb[k] = 8'($urandom); mc[k] = 8'($urandom); end
    acc = 0; got = 0;
    if0.out_ready = 1'b0; if0.in_valid = 1'b1; if0.rnd_valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive0(acc, ma[acc], mb[acc], mc[acc], 8'($urandom));
      #1;
      fire = if0.in_ready;
      step();
      if (fire) acc++;
    end
    #1;
    tests++; if (acc !== 2) begin fails++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    tests++; if (if0.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full: got %b want 0", if0.in_ready); end
    tests++; if (if0.rnd_ready !== 1'b0) begin fails++; $display("FAIL bp_rnd_ready_full: got %b want 0", if0.rnd_ready); end
    snap = if0.out;
    step(); step(); step();
    tests++; if (if0.out !== snap) begin fails++; $display("FAIL bp_out_stable: got %h want %h", if0.out, snap); end
    tests++; if (if0.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid_held: got %b want 1", if0.out_valid); end
    tests++; if (um2(snap) !== it_x[0]) begin fails++; $display("FAIL bp_head_value: got %h want %h", um2(snap), it_x[0]); end
    if0.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if (acc < 3) drive0(acc, ma[acc], mb[acc], mc[acc], 8'($urandom));
      else if0.in_valid = 1'b0;
      #1;
      fire = if0.in_valid && if0.in_ready;
      ov   = if0.out_valid;
      val  = um2(if0.out);
      step();
      if (fire) acc++;
      if (ov) begin res[got] = val; got++; end
    end
    if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
    tests++; if (got !== 3) begin fails++; $display("FAIL bp_drain_count: got %0d want 3", got); end
    tests++; if (acc !== 3) begin fails++; $display("FAIL bp_total_accepted: got %0d want 3", acc); end
    for (int k = 0; k < 3 && k < got; k++) begin
      tests++; if (res[k] !== it_x[k]) begin fails++; $display("FAIL bp_order[%0d]: got %h want %h", k, res[k], it_x[k]); end
    end
    step();
    tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got %b want 0", if0.out_valid); end
  endtask

  task automatic test_rnd_stall();
    int nout, when;
    if0.out_ready = 1'b1;
    drive0(1, 8'h3E, 8'h91, 8'h07, 8'h5C);
    if0.in_valid = 1'b1; if0.rnd_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      tests++; if (if0.rnd_ready !== 1'b1) begin fails++; $display("FAIL stall_rnd_ready[%0d]: got %b want 1", cyc, if0.rnd_ready); end
      tests++; if (if0.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b want 0", cyc, if0.in_ready); end
      tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL stall_out_valid[%0d]: got %b want 0", cyc, if0.out_valid); end
      step();
    end
    if0.rnd_valid = 1'b1;
    #1;
    tests++; if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", if0.in_ready); end
    step();
    if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
    nout = 0; when = -1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (if0.out_valid === 1'b1) begin
        nout++;
        if (when < 0) when = cyc;
        tests++; if (um2(if0.out) !== it_x[1]) begin fails++; $display("FAIL stall_value: got %h want %h", um2(if0.out), it_x[1]); end
      end
      step();
    end
    tests++; if (nout !== 1) begin fails++; $display("FAIL stall_single_T: got %0d outputs want 1", nout); end
    tests++; if (when !== 1) begin fails++; $display("FAIL stall_latency: got cycle %0d want 1", when); end
  endtask

  task automatic test_reset_mid();
    if0.out_ready = 1'b0;
    if0.in_valid = 1'b1; if0.rnd_valid = 1'b1;
    drive0(0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    step();
    drive0(2, 8'h11, 8'h22, 8'h33, 8'h44);
    step();
    if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
    #1;
    tests++; if (if0.out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_full_valid: got %b want 1", if0.out_valid); end
    if0.rnd_valid = 1'b1;
    #1;
    tests++; if (if0.in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_full_ready: got %b want 0", if0.in_ready); end
    if0.rnd_valid = 1'b0;
    rst = 1'b1;
    if0.out_ready = 1'b1; if0.in_valid = 1'b1; if0.rnd_valid = 1'b1;
    #1;
    tests++; if (if0.in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready: got %b want 0", if0.in_ready); end
    tests++; if (if0.rnd_ready !== 1'b0) begin fails++; $display("FAIL rstmid_rnd_ready: got %b want 0", if0.rnd_ready); end
    step();
    tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b want 0", if0.out_valid); end
    tests++; if (if0.out !== 16'h0000) begin fails++; $display("FAIL rstmid_out: got %h want 0000", if0.out); end
    rst = 1'b0;
    drive0(1, 8'h5D, 8'hE6, 8'h29, 8'h8F);
    step();
    if0.in_valid = 1'b0; if0.rnd_valid = 1'b0;
    tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_lat1: got %b want 0", if0.out_valid); end
    step();
    tests++; if (if0.out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_lat2: got %b want 1", if0.out_valid); end
    tests++; if (um2(if0.out) !== it_x[1]) begin fails++; $display("FAIL rstmid_value: got %h want %h", um2(if0.out), it_x[1]); end
    step();
    tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_drain: got %b want 0", if0.out_valid); end
  endtask

  task automatic test_random_d3();
    logic [3:0] q [$];
    logic [3:0] a, b, c, expv, val;
    int sent, recv, cyc;
    logic fin, fout;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
      if2.ina = sh3(a, 4'($urandom), 4'($urandom));
      if2.inb = sh3(b, 4'($urandom), 4'($urandom));
      if2.inc = sh3(c, 4'($urandom), 4'($urandom));
      if2.rnd = 12'($urandom);
      if2.in_valid  = (sent < 1000) && ($urandom_range(3, 0) != 0);
      if2.rnd_valid = ($urandom_range(3, 0) != 0);
      if2.out_ready = ($urandom_range(3, 0) != 0);
      #1;
      fin  = if2.in_valid && if2.in_ready;
      fout = if2.out_valid && if2.out_ready;
      val  = um3(if2.out);
      if (fout) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_d3_unexpected: got %h want no output", val);
        end else begin
          expv = q.pop_front();
          if (val !== expv) begin fails++; $display("FAIL rand_d3_item%0d: got %h want %h", recv, val, expv); end
        end
        recv++;
      end
      if (fin) begin
        q.push_back((a & b) ^ c);
        sent++;
      end
      step();
      cyc++;
    end
    if2.in_valid = 1'b0; if2.rnd_valid = 1'b0;
    tests++; if (recv !== 1000) begin fails++; $display("FAIL rand_d3_count: got %0d want 1000 within bound", recv); end
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL rand_d3_leftover: got %0d want 0", q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    if0.in_valid = 1'b0; if0.rnd_valid = 1'b0; if0.out_ready = 1'b0;
    if0.ina = '0; if0.inb = '0; if0.inc = '0; if0.rnd = '0;
    if2.in_valid = 1'b0; if2.rnd_valid = 1'b0; if2.out_ready = 1'b1;
    if2.ina = '0; if2.inb = '0; if2.inc = '0; if2.rnd = '0;
    test_reset();
    test_basic_rnd_swap();
    test_backpressure();
    test_rnd_stall();
    test_reset_mid();
    test_random_d3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
